// File: rtl/i2c_bus_monitor.sv
// Passive I2C receive-side sequencer: START/STOP detection, byte framing with ACK capture, small output FIFO.
// Optional ADDR_MATCH_EN: only transactions whose first byte addresses DEV_ADDR are queued.
module i2c_bus_monitor #(
  parameter int         DEPTH    = 4,
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic [7:0] byte_data,
  output logic       byte_ack,
  output logic       byte_first,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t         state_r;
  logic           scl_q_r;
  logic           sda_q_r;
  logic [2:0]     bit_cnt_r;
  logic [7:0]     shift_r;
  logic           first_r;
  logic           busy_r;
  logic           start_pulse_r;
  logic           stop_pulse_r;
  logic           overflow_r;

  logic [7:0]     data_mem_r  [DEPTH];
  logic           ack_mem_r   [DEPTH];
  logic           first_mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  logic start_s;
  logic stop_s;
  logic rise_s;
  logic byte_done_s;
  logic keep_s;
  logic push_s;
  logic pop_s;
  logic full_s;
  logic wr_en_s;
  logic drop_s;

  assign start_s     = scl_q_r & scl & sda_q_r & ~sda;
  assign stop_s      = scl_q_r & scl & ~sda_q_r & sda;
  assign rise_s      = ~scl_q_r & scl;
  assign byte_done_s = (state_r == ACK) & rise_s & ~start_s & ~stop_s;

`ifdef ADDR_MATCH_EN
  logic supp_r;

  // A mismatching first byte suppresses the rest of the transaction until the next START or STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      supp_r <= 1'b0;
    end else if (start_s | stop_s) begin
      supp_r <= 1'b0;
    end else if (byte_done_s & first_r & (shift_r[7:1] != DEV_ADDR)) begin
      supp_r <= 1'b1;
    end else begin
      supp_r <= supp_r;
    end
  end

  assign keep_s = ~supp_r & (~first_r | (shift_r[7:1] == DEV_ADDR));
`else
  logic unused_dev_addr_s;
  assign unused_dev_addr_s = ^DEV_ADDR;
  assign keep_s            = 1'b1;
`endif

  assign push_s  = byte_done_s & keep_s;
  assign pop_s   = (count_r != CW'(0)) & byte_ready;
  assign full_s  = (count_r == CW'(DEPTH));
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // Line history, pulses, busy flag and the bit-framing state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q_r       <= 1'b1;
      sda_q_r       <= 1'b1;
      state_r       <= IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'd0;
      first_r       <= 1'b0;
      busy_r        <= 1'b0;
      start_pulse_r <= 1'b0;
      stop_pulse_r  <= 1'b0;
    end else begin
      scl_q_r       <= scl;
      sda_q_r       <= sda;
      start_pulse_r <= start_s;
      stop_pulse_r  <= stop_s;
      if (start_s) begin
        busy_r    <= 1'b1;
        state_r   <= DATA;
        bit_cnt_r <= 3'd0;
        shift_r   <= 8'd0;
        first_r   <= 1'b1;
      end else if (stop_s) begin
        busy_r    <= 1'b0;
        state_r   <= IDLE;
        bit_cnt_r <= 3'd0;
        shift_r   <= 8'd0;
        first_r   <= 1'b0;
      end else if (rise_s) begin
        case (state_r)
          IDLE: state_r <= IDLE;
          DATA: begin
            shift_r   <= {shift_r[6:0], sda};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ACK;
            end else begin
              state_r <= DATA;
            end
          end
          ACK: begin
            first_r <= 1'b0;
            state_r <= DATA;
          end
          default: state_r <= IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  // Output FIFO; a push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i]  <= 8'd0;
        ack_mem_r[i]   <= 1'b0;
        first_mem_r[i] <= 1'b0;
      end
      wr_ptr_r   <= AW'(0);
      rd_ptr_r   <= AW'(0);
      count_r    <= CW'(0);
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        data_mem_r[wr_ptr_r]  <= shift_r;
        ack_mem_r[wr_ptr_r]   <= sda;
        first_mem_r[wr_ptr_r] <= first_r;
        wr_ptr_r              <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign byte_data   = data_mem_r[rd_ptr_r];
  assign byte_ack    = ack_mem_r[rd_ptr_r];
  assign byte_first  = first_mem_r[rd_ptr_r];
  assign byte_valid  = (count_r != CW'(0));
  assign busy        = busy_r;
  assign start_pulse = start_pulse_r;
  assign stop_pulse  = stop_pulse_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboard bench for i2c_bus_monitor: bus tasks push expected bytes, a negedge monitor pops and compares.
module tb_i2c_bus_monitor;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda;
  logic [7:0] byte_data;
  logic       byte_ack;
  logic       byte_first;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       start_pulse;
  logic       stop_pulse;
  logic       overflow;

  int         checks    = 0;
  int         errors    = 0;
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  logic       prev_start = 1'b0;
  logic       prev_stop  = 1'b0;
  logic [9:0] exp_q[$];
  bit         tb_first = 1'b0;
  bit         tb_supp  = 1'b0;

  i2c_bus_monitor #(.DEPTH(4), .DEV_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .byte_data(byte_data), .byte_ack(byte_ack), .byte_first(byte_first),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Monitor: pulse widths/counts and scoreboard comparison on every accepted byte.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      prev_start = 1'b0;
      prev_stop  = 1'b0;
    end else begin
      if (start_pulse) begin
        chk("start_pulse_width", 32'(prev_start), 32'd0);
        start_cnt++;
      end
      if (stop_pulse) begin
        chk("stop_pulse_width", 32'(prev_stop), 32'd0);
        stop_cnt++;
      end
      prev_start = start_pulse;
      prev_stop  = stop_pulse;
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: actual first=%0d ack=%0d data=%0h required none",
                   byte_first, byte_ack, byte_data);
        end else begin
          e = exp_q.pop_front();
          chk("byte_entry", 32'({byte_first, byte_ack, byte_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_set(input logic s, input logic d);
    scl = s;
    sda = d;
    step(HOLD);
  endtask

  task automatic i2c_start();
    int sc;
    sc = start_cnt;
    bus_set(1'b0, 1'b1);
    bus_set(1'b1, 1'b1);
    bus_set(1'b1, 1'b0);
    tb_first = 1'b1;
    tb_supp  = 1'b0;
    chk("start_count", 32'(start_cnt), 32'(sc + 1));
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic i2c_stop();
    int sc;
    sc = stop_cnt;
    bus_set(1'b0, 1'b0);
    bus_set(1'b1, 1'b0);
    bus_set(1'b1, 1'b1);
    tb_first = 1'b0;
    tb_supp  = 1'b0;
    chk("stop_count", 32'(stop_cnt), 32'(sc + 1));
    chk("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus_set(1'b0, d[7-i]);
      bus_set(1'b1, d[7-i]);
    end
  endtask

  // cap=0 marks a byte the FIFO cannot hold; rdy_on_ack raises byte_ready with the 9th SCL rise.
  task automatic send_byte(input logic [7:0] d, input logic ack, input bit cap,
                           input bit chk_valid, input bit rdy_on_ack);
    bit keep;
    send_bits(d, 8);
    bus_set(1'b0, ack);
    keep = cap;
`ifdef ADDR_MATCH_EN
    if (tb_first && (d[7:1] != 7'h50)) tb_supp = 1'b1;
    if (tb_supp) keep = 1'b0;
`endif
    if (keep) exp_q.push_back({tb_first, ack, d});
    tb_first = 1'b0;
    scl = 1'b1;
    sda = ack;
    if (rdy_on_ack) byte_ready = 1'b1;
    if (chk_valid) begin
      @(negedge clk);
      chk("valid_before_push", 32'(byte_valid), 32'd0);
      @(negedge clk);
      chk("valid_after_push", 32'(byte_valid), 32'(keep));
      @(posedge clk);
      #1;
      step(HOLD - 2);
    end else begin
      step(HOLD);
    end
  endtask

  task automatic drain();
    byte_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || byte_valid); i++) step(1);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid_low", 32'(byte_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    scl        = 1'b1;
    sda        = 1'b1;
    byte_ready = 1'b0;
    step(4);
    rst = 1'b0;
    step(1);
    chk("reset_outputs",
        32'({byte_valid, busy, start_pulse, stop_pulse, overflow, byte_ack, byte_first, byte_data}),
        32'd0);

    // One queued byte, then reset in the middle of the next byte.
    i2c_start();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(byte_valid), 32'd1);
    send_bits(8'hFF, 4);
    rst = 1'b1;
    step(1);
    chk("reset_mid_valid", 32'(byte_valid), 32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tb_first = 1'b0;
    tb_supp  = 1'b0;
    step(2);

    // Two bytes with ACK then NACK, drained as they arrive.
    byte_ready = 1'b1;
    i2c_start();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    i2c_stop();
    drain();

    // Partial byte abandoned by a repeated START.
    i2c_start();
    send_bits(8'hB7, 5);
    i2c_start();
    send_byte(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    i2c_stop();
    drain();

    // Full FIFO with a pop coinciding with the push.
    byte_ready = 1'b0;
    i2c_start();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_no_overflow_yet", 32'(overflow), 32'd0);
    send_byte(8'h44, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("full_with_pop_overflow", 32'(overflow), 32'd0);
    i2c_stop();
    drain();

    // Five bytes into four entries with no consumer.
    byte_ready = 1'b0;
    i2c_start();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("overflow_valid", 32'(byte_valid), 32'd1);
    i2c_stop();
    drain();
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Matching and non-matching address transactions.
    i2c_start();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    i2c_stop();
    i2c_start();
    send_byte(8'hA2, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    i2c_stop();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
